// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 512;
  localparam int DEF_AF_TH = DEF_DEPTH - 2;
  localparam int DEF_AE_TH = 2;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Ceiling log2; usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: write port on clk_a, read port registered or combinational.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = clog2(DEPTH),
  parameter int ASYNC_RD = 0
)(
  input  logic             clk_a,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_a) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Only the output register is reset; storage contents are left as-is.
  always_ff @(posedge clk_a) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = (ASYNC_RD != 0) ? r_mem[i_raddr] : r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, occupancy count, threshold flags,
// overflow/underflow pulses and selectable standard or FWFT read mode.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_DEPTH,
  parameter int AF_TH      = FIFO_DEPTH - 2,
  parameter int AE_TH      = DEF_AE_TH,
  parameter int FWFT       = MODE_STD
)(
  input  logic                              clk_a,
  input  logic                              rst,
  input  logic [FIFO_WIDTH-1:0]             din_a,
  input  logic                              wen_a,
  input  logic                              ren_b,
  output logic [FIFO_WIDTH-1:0]             dout_b,
  output logic                              dout_valid,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic [clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int AW      = clog2(FIFO_DEPTH);
  localparam int CW      = clog2(FIFO_DEPTH + 1);
  localparam bit IS_FWFT = (FWFT == MODE_FWFT);

  if (FIFO_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo: FIFO_WIDTH must be >= 1");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo: FIFO_DEPTH must be >= 2");
  end
  if (AF_TH < 1 || AF_TH > FIFO_DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_TH must be in 1..FIFO_DEPTH");
  end
  if (AE_TH < 0 || AE_TH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo: AE_TH must be in 0..FIFO_DEPTH-1");
  end
  if (FWFT != MODE_STD && FWFT != MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo: FWFT must be MODE_STD or MODE_FWFT");
  end

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_dout_valid;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [FIFO_WIDTH-1:0] w_mem_rdata;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // A full FIFO still accepts a write when a read frees a slot at the same edge.
  assign w_rd_acc = ~rst & ren_b & ~w_empty;
  assign w_wr_acc = ~rst & wen_a & (~w_full | w_rd_acc);

  always_ff @(posedge clk_a) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_overflow   <= wen_a & ~w_wr_acc;
      r_underflow  <= ren_b & ~w_rd_acc;
      r_dout_valid <= w_rd_acc;
    end
  end

  fifo_mem #(
    .WIDTH    (FIFO_WIDTH),
    .DEPTH    (FIFO_DEPTH),
    .AW       (AW),
    .ASYNC_RD (IS_FWFT ? 1 : 0)
  ) u_mem (
    .clk_a   (clk_a),
    .i_rst   (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (din_a),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  // FWFT output is forced to zero while empty so it shows its reset value.
  assign dout_b       = IS_FWFT ? (w_empty ? '0 : w_mem_rdata) : w_mem_rdata;
  assign dout_valid   = IS_FWFT ? ~w_empty : r_dout_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CW'(AF_TH));
  assign almost_empty = (r_count <= CW'(AE_TH));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
